instruction_fetcher: RTL and testbench
======================================

# instruction_fetcher

Fetch stage that feeds the decoder. Holds the fetch PC, requests 32-bit instruction words from the memory controller over a request/done handshake, and applies static next-PC prediction: JAL taken, backward branch taken, everything else PC+4. Buffers fetched words in a small FIFO and presents the head to the decoder one instruction per cycle while the back end is not stalled. Flushes and redirects on `rollback`.

## Interface
Parameters:
- `QUEUE_LOG`, default 2: the instruction queue holds 2^QUEUE_LOG entries of {inst, pc, predicted-taken}.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rdy`  in  1  global enable; when low, all state holds.
- `rollback`  in  1  misprediction flush.
- `rollback_pc`  in  32  redirect target, valid with `rollback`.
- `issue_stall`  in  1  ROB, RS or LSB cannot accept an instruction this cycle.
- `mem_req`  out  1  fetch request to the memory controller.
- `mem_addr`  out  32  fetch address.
- `mem_done`  in  1  one-cycle pulse; `mem_inst` is valid in the same cycle.
- `mem_inst`  in  32  fetched word.
- `inst_rdy`  out  1  queue head is valid and is consumed this cycle.
- `inst`  out  32  head instruction word.
- `inst_PC`  out  32  head instruction address.
- `inst_is_Jump`  out  1  head was predicted taken.

## Operation
- Registers: `pc`, FSM state, queue (head pointer, tail pointer, count of width QUEUE_LOG+1), `mem_req`, `mem_addr`.
- FSM:
  - IDLE: if count < 2^QUEUE_LOG and there is no rollback, go to BUSY; set `mem_req`=1 and `mem_addr`=pc.
  - BUSY: on `mem_done`, push {mem_inst, mem_addr, taken}, set pc to the predicted next PC, clear `mem_req`, and go to IDLE.
  - DROP: wait for `mem_done`, discard the word, clear `mem_req`, and go to IDLE. pc already holds `rollback_pc`.
- While `mem_req` is high, `mem_addr` is stable. There is never more than one outstanding request.
- Prediction decodes `mem_inst[6:0]`; all arithmetic is 32-bit and wraps:
  - 1101111 (JAL): next = addr + sext({i[31], i[19:12], i[20], i[30:21], 0}); taken=1.
  - 1100011 (branch) with i[31]=1: next = addr + sext({i[31], i[7], i[30:25], i[11:8], 0}); taken=1.
  - Any other opcode (including JALR and forward branches): next = addr + 4; taken=0.
- Dispatch:
  - `inst_rdy` = rdy & !rst & !rollback & (count≠0) & !issue_stall. It is combinational.
  - `inst`, `inst_PC` and `inst_is_Jump` always show the head entry.
  - The head pops on each clock edge where `inst_rdy`=1.
- Simultaneous push and pop leave count unchanged. Overflow is impossible because a fetch starts only when count < depth and there are no outstanding requests. Pointers wrap modulo depth.
- Rollback (sampled on the edge, rdy=1):
  - Queue count and pointers clear, and pc ← `rollback_pc`.
  - If BUSY without `mem_done` in that cycle, go to DROP; `mem_req` stays high until done.
  - If BUSY with `mem_done` in the same cycle, discard the word, clear `mem_req`, and go to IDLE.
  - If IDLE or DROP, state is unchanged.
  - Rollback overrides push and pop.
- `mem_done` while IDLE is ignored.
- rdy=0: no state changes, `inst_rdy`=0, and `mem_req`/`mem_addr` hold.

## Timing
- Reset values: pc=0, state IDLE, `mem_req`=0, `mem_addr`=0, queue empty and all entries 0. Therefore `inst_rdy`=0 and `inst`/`inst_PC`/`inst_is_Jump`=0.
- Reset mid-fetch returns to IDLE immediately; the late `mem_done` is ignored.
- The first `mem_req` rises on the first edge after reset deasserts, with `mem_addr`=0.
- If `mem_done` arrives in cycle t, the word is pushed at edge t, and `inst_rdy` can be 1 in cycle t+1 (if the queue was empty and there is no stall).
- The next request rises at edge t+1 if there is room.
- Steady fetch period is memory latency + 2 cycles.
- After rollback at edge r: `inst_rdy`=0 in cycle r. From IDLE, `mem_req` with `mem_addr`=`rollback_pc` rises at edge r+1. From DROP, it rises one edge after DROP ends.
- Dispatch rate: one instruction per cycle while the queue is non-empty.

## Test plan
- Reset; memory answers 0x00100093 (addi) two cycles after each request → `mem_addr`=0x0. `inst_rdy`=1 with `inst_PC`=0x0 and `inst_is_Jump`=0 in the cycle after `mem_done`. The next `mem_addr` is 0x4.
- 0x0100006F (jal x0,+16) returned for addr 0x8 → `inst_is_Jump`=1, next `mem_addr`=0x18.
- 0xFE000CE3 (beq x0,x0,-8) at 0x20 → next addr 0x18, jump=1. 0x00000463 (beq +8) at 0x18 → next addr 0x1C, jump=0.
- Hold `issue_stall`=1 → after 4 pushes (PCs 0,4,8,C), `mem_req` stays 0. Release `issue_stall` → `inst_rdy` is high for 4 consecutive cycles with PCs 0,4,8,C, then the fetch of 0x10 starts.
- Rollback with `rollback_pc`=0x100 while a request to 0x40 is outstanding → no `inst_rdy` for 0x40. After `mem_done`, the next request has `mem_addr`=0x100. Also repeat with rollback and `mem_done` in the same cycle.
- rdy=0 for 3 cycles during a queued, outstanding fetch → `inst_rdy`=0 and all outputs hold. After rdy returns to 1, the order is preserved with no duplicated or lost instructions.

Source files
------------

// File: rtl/instruction_fetcher.sv
// Fetch stage: issues one memory fetch at a time, predicts the next PC statically
// (JAL and backward branches taken), and queues fetched words for the decoder.
module instruction_fetcher #(
    parameter int QUEUE_LOG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    input  logic        issue_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_inst,
    output logic        inst_rdy,
    output logic [31:0] inst,
    output logic [31:0] inst_PC,
    output logic        inst_is_Jump
);

    localparam int DEPTH = 1 << QUEUE_LOG;
    localparam int CW    = QUEUE_LOG + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic                 mem_req_q, mem_req_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [QUEUE_LOG-1:0] head_q, head_d;
    logic [QUEUE_LOG-1:0] tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;

    logic [31:0] q_inst_q [DEPTH];
    logic [31:0] q_inst_d [DEPTH];
    logic [31:0] q_pc_q   [DEPTH];
    logic [31:0] q_pc_d   [DEPTH];
    logic        q_jmp_q  [DEPTH];
    logic        q_jmp_d  [DEPTH];

    logic        push;
    logic        pop;
    logic        full;
    logic [31:0] jal_off;
    logic [31:0] br_off;
    logic [31:0] pred_pc;
    logic        pred_taken;

    // Count never exceeds DEPTH, so its top bit alone marks a full queue.
    assign full = count_q[QUEUE_LOG];

    assign jal_off = {{11{mem_inst[31]}}, mem_inst[31], mem_inst[19:12],
                      mem_inst[20], mem_inst[30:21], 1'b0};
    assign br_off  = {{19{mem_inst[31]}}, mem_inst[31], mem_inst[7],
                      mem_inst[30:25], mem_inst[11:8], 1'b0};

    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = mem_addr_q + 32'd4;
        if (mem_inst[6:0] == 7'b1101111) begin
            pred_taken = 1'b1;
            pred_pc    = mem_addr_q + jal_off;
        end else if (mem_inst[6:0] == 7'b1100011 && mem_inst[31]) begin
            pred_taken = 1'b1;
            pred_pc    = mem_addr_q + br_off;
        end
    end

    assign inst_rdy     = rdy & ~rst & ~rollback & (count_q != '0) & ~issue_stall;
    assign pop          = inst_rdy;
    assign inst         = q_inst_q[head_q];
    assign inst_PC      = q_pc_q[head_q];
    assign inst_is_Jump = q_jmp_q[head_q];
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            q_inst_d[i] = q_inst_q[i];
            q_pc_d[i]   = q_pc_q[i];
            q_jmp_d[i]  = q_jmp_q[i];
        end

        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (!full && !rollback) begin
                        state_d    = BUSY;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                    end
                end
                BUSY: begin
                    if (mem_done) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        if (!rollback) begin
                            push = 1'b1;
                            pc_d = pred_pc;
                        end
                    end else if (rollback) begin
                        // Request still in flight: keep it open and discard its answer.
                        state_d = DROP;
                    end
                end
                DROP: begin
                    if (mem_done) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (rollback) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                pc_d    = rollback_pc;
            end else begin
                if (push) begin
                    q_inst_d[tail_q] = mem_inst;
                    q_pc_d[tail_q]   = mem_addr_q;
                    q_jmp_d[tail_q]  = pred_taken;
                    tail_d           = tail_q + QUEUE_LOG'(1);
                end
                if (pop) begin
                    head_d = head_q + QUEUE_LOG'(1);
                end
                if (push && !pop) begin
                    count_d = count_q + CW'(1);
                end else if (!push && pop) begin
                    count_d = count_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_inst_q[gi] <= '0;
                    q_pc_q[gi]   <= '0;
                    q_jmp_q[gi]  <= 1'b0;
                end else begin
                    q_inst_q[gi] <= q_inst_d[gi];
                    q_pc_q[gi]   <= q_pc_d[gi];
                    q_jmp_q[gi]  <= q_jmp_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: a two-cycle-latency memory model,
// cycle-exact checks, and request/dispatch logs compared against hand-computed sequences.
module tb_instruction_fetcher;

    localparam int LAT   = 2;
    localparam int BOUND = 200;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] JAL  = 32'h0100006F;
    localparam logic [31:0] BFWD = 32'h00000463;
    localparam logic [31:0] BBCK = 32'hFE000CE3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        issue_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_inst;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] inst_PC;
    logic        inst_is_Jump;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_map [logic [31:0]];
    logic        pending;
    int          cnt;
    logic [31:0] pend_addr;
    logic        prev_req;
    logic [31:0] req_log [$];
    logic [31:0] disp_pc [$];
    logic [31:0] disp_inst [$];
    logic        disp_jmp [$];

    instruction_fetcher dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .rollback     (rollback),
        .rollback_pc  (rollback_pc),
        .issue_stall  (issue_stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_done     (mem_done),
        .mem_inst     (mem_inst),
        .inst_rdy     (inst_rdy),
        .inst         (inst),
        .inst_PC      (inst_PC),
        .inst_is_Jump (inst_is_Jump)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("check %s = 0x%08h ok", tag, got);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_map.exists(a)) return mem_map[a];
        return ADDI;
    endfunction

    // Memory model: answers LAT enabled cycles after a request, holds done until an enabled edge.
    task automatic mem_update();
        if (rst) begin
            pending  = 1'b0;
            cnt      = 0;
            mem_done = 1'b0;
        end else if (mem_done) begin
            if (rdy) mem_done = 1'b0;
        end else if (pending) begin
            if (rdy) begin
                cnt--;
                if (cnt == 0) begin
                    mem_done = 1'b1;
                    mem_inst = mem_word(pend_addr);
                    pending  = 1'b0;
                end
            end
        end else if (mem_req) begin
            pending   = 1'b1;
            cnt       = LAT;
            pend_addr = mem_addr;
        end
    endtask

    task automatic monitor();
        if (!rst) begin
            if (mem_req && !prev_req) req_log.push_back(mem_addr);
            prev_req = mem_req;
            if (inst_rdy) begin
                disp_pc.push_back(inst_PC);
                disp_inst.push_back(inst);
                disp_jmp.push_back(inst_is_Jump);
            end
        end
    endtask

    task automatic step();
        #1;
        monitor();
        @(posedge clk);
        #1;
        mem_update();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic stall);
        rst         = 1'b1;
        rdy         = 1'b1;
        rollback    = 1'b0;
        rollback_pc = '0;
        issue_stall = stall;
        #1;
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_inst_rdy", 32'(inst_rdy), 32'd0);
        req_log.delete();
        disp_pc.delete();
        disp_inst.delete();
        disp_jmp.delete();
        mem_map.delete();
        prev_req = 1'b0;
        pending  = 1'b0;
        cnt      = 0;
        mem_done = 1'b0;
        mem_inst = '0;
        step();
        step();
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_inst", inst, 32'd0);
        check_val("rst_inst_PC", inst_PC, 32'd0);
        check_val("rst_inst_jump", 32'(inst_is_Jump), 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] addr, input string tag);
        int n = 0;
        while (!(mem_req && mem_addr == addr) && n < BOUND) begin
            step();
            n++;
        end
        check_val(tag, 32'(mem_req && mem_addr == addr), 32'd1);
    endtask

    logic [31:0] exp_req  [7] = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h1C, 32'h20, 32'h18};
    logic [31:0] exp_pc   [6] = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h1C, 32'h20};
    logic [31:0] exp_inst [6] = '{ADDI, ADDI, JAL, BFWD, ADDI, BBCK};
    logic        exp_jmp  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        // Basic fetch timing plus static prediction over a jal / forward / backward branch loop.
        do_reset(1'b0);
        mem_map[32'h8]  = JAL;
        mem_map[32'h18] = BFWD;
        mem_map[32'h20] = BBCK;
        step();
        check_val("t1_req", 32'(mem_req), 32'd1);
        check_val("t1_addr", mem_addr, 32'h0);
        check_val("t1_rdy_before", 32'(inst_rdy), 32'd0);
        step();
        step();
        check_val("t1_rdy_in_done", 32'(inst_rdy), 32'd0);
        step();
        check_val("t1_inst_rdy", 32'(inst_rdy), 32'd1);
        check_val("t1_inst_PC", inst_PC, 32'h0);
        check_val("t1_inst", inst, ADDI);
        check_val("t1_jump", 32'(inst_is_Jump), 32'd0);
        check_val("t1_req_low", 32'(mem_req), 32'd0);
        step();
        check_val("t1_next_req", 32'(mem_req), 32'd1);
        check_val("t1_next_addr", mem_addr, 32'h4);
        check_val("t1_rdy_drained", 32'(inst_rdy), 32'd0);
        repeat (31) step();
        for (int i = 0; i < 7; i++)
            check_val($sformatf("t2_req%0d", i), req_log[i], exp_req[i]);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("t2_pc%0d", i), disp_pc[i], exp_pc[i]);
            check_val($sformatf("t2_inst%0d", i), disp_inst[i], exp_inst[i]);
            check_val($sformatf("t2_jmp%0d", i), 32'(disp_jmp[i]), 32'(exp_jmp[i]));
        end

        // Stalled back end fills the queue, then drains one per cycle.
        do_reset(1'b1);
        repeat (24) step();
        check_val("t4_full_no_req", 32'(mem_req), 32'd0);
        check_val("t4_req_count", 32'(req_log.size()), 32'd4);
        check_val("t4_last_req", req_log[3], 32'hC);
        check_val("t4_stalled_rdy", 32'(inst_rdy), 32'd0);
        check_val("t4_head_inst", inst, ADDI);
        issue_stall = 1'b0;
        #1;
        check_val("t4_drain0_rdy", 32'(inst_rdy), 32'd1);
        check_val("t4_drain0_pc", inst_PC, 32'h0);
        for (int i = 1; i < 4; i++) begin
            step();
            check_val($sformatf("t4_drain%0d_rdy", i), 32'(inst_rdy), 32'd1);
            check_val($sformatf("t4_drain%0d_pc", i), inst_PC, 32'(4 * i));
        end
        step();
        check_val("t4_empty", 32'(inst_rdy), 32'd0);
        check_val("t4_refetch_req", 32'(mem_req), 32'd1);
        check_val("t4_refetch_addr", mem_addr, 32'h10);

        // Rollback while 0x40 is outstanding with two words queued.
        do_reset(1'b0);
        wait_req(32'h38, "t5_wait_38");
        issue_stall = 1'b1;
        wait_req(32'h40, "t5_wait_40");
        issue_stall = 1'b0;
        rollback    = 1'b1;
        rollback_pc = 32'h100;
        #1;
        check_val("t5_rb_rdy", 32'(inst_rdy), 32'd0);
        step();
        rollback = 1'b0;
        #1;
        check_val("t5_drop_req", 32'(mem_req), 32'd1);
        check_val("t5_drop_addr", mem_addr, 32'h40);
        check_val("t5_flushed", 32'(inst_rdy), 32'd0);
        step();
        check_val("t5_drop_done_rdy", 32'(inst_rdy), 32'd0);
        step();
        check_val("t5_drop_end_req", 32'(mem_req), 32'd0);
        check_val("t5_discarded", 32'(inst_rdy), 32'd0);
        step();
        check_val("t5_redir_req", 32'(mem_req), 32'd1);
        check_val("t5_redir_addr", mem_addr, 32'h100);
        repeat (3) step();
        check_val("t5_redir_rdy", 32'(inst_rdy), 32'd1);
        check_val("t5_redir_pc", inst_PC, 32'h100);

        // Rollback coinciding with mem_done.
        begin
            int n = 0;
            while (!mem_done && n < BOUND) begin
                step();
                n++;
            end
        end
        check_val("t5b_done_seen", 32'(mem_done), 32'd1);
        check_val("t5b_done_addr", mem_addr, 32'h104);
        rollback    = 1'b1;
        rollback_pc = 32'h200;
        step();
        rollback = 1'b0;
        #1;
        check_val("t5b_req_low", 32'(mem_req), 32'd0);
        check_val("t5b_discarded", 32'(inst_rdy), 32'd0);
        step();
        check_val("t5b_redir_req", 32'(mem_req), 32'd1);
        check_val("t5b_redir_addr", mem_addr, 32'h200);
        repeat (3) step();
        check_val("t5b_redir_rdy", 32'(inst_rdy), 32'd1);
        check_val("t5b_redir_pc", inst_PC, 32'h200);

        // rdy low for three cycles with two queued words and fetch of 0x8 outstanding.
        do_reset(1'b1);
        wait_req(32'h8, "t6_wait_8");
        step();
        rdy         = 1'b0;
        issue_stall = 1'b0;
        #1;
        check_val("t6_hold_rdy0", 32'(inst_rdy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("t6_hold%0d_rdy", i), 32'(inst_rdy), 32'd0);
            check_val($sformatf("t6_hold%0d_req", i), 32'(mem_req), 32'd1);
            check_val($sformatf("t6_hold%0d_addr", i), mem_addr, 32'h8);
            check_val($sformatf("t6_hold%0d_pc", i), inst_PC, 32'h0);
        end
        rdy = 1'b1;
        repeat (24) step();
        check_val("t6_disp_count", 32'(disp_pc.size()), 32'd8);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("t6_pc%0d", i), disp_pc[i], 32'(4 * i));
            check_val($sformatf("t6_inst%0d", i), disp_inst[i], ADDI);
        end

        // Asynchronous reset mid-fetch drops the request immediately.
        wait_req(32'h24, "t7_wait_24");
        rst = 1'b1;
        #1;
        check_val("t7_async_req", 32'(mem_req), 32'd0);
        check_val("t7_async_addr", mem_addr, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
